sign_mag_bin2bcd_8b: RTL and testbench

Sequential converter that consumes the 8-bit sign-magnitude sum from the ROM adder. It produces a sign flag and three BCD digits for the seven-segment display driver. It replaces the plain binary-to-BCD stage, which only saw the 7-bit magnitude. Conversion uses iterative shift-add-3 (double dabble), one magnitude bit per clock, with a start/ready/done_tick handshake.

---
 rtl/sign_mag_bin2bcd_8b_if.sv | 36 +++
 rtl/sign_mag_bin2bcd_8b.sv | 107 ++++++++++
 tb/tb_sign_mag_bin2bcd_8b.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sign_mag_bin2bcd_8b_if.sv
// Handshake and result bundle between the sign-magnitude BCD converter and its user.
// The master drives start/sm_in; the slave (the converter) drives status and the result digits.
interface sign_mag_bin2bcd_8b_if #(
    parameter int unsigned MAG_W = 7
);
    logic             start;
    logic [MAG_W:0]   sm_in;
    logic             ready;
    logic             done_tick;
    logic             sign;
    logic [3:0]       bcd2;
    logic [3:0]       bcd1;
    logic [3:0]       bcd0;

    modport master (
        output start,
        output sm_in,
        input  ready,
        input  done_tick,
        input  sign,
        input  bcd2,
        input  bcd1,
        input  bcd0
    );

    modport slave (
        input  start,
        input  sm_in,
        output ready,
        output done_tick,
        output sign,
        output bcd2,
        output bcd1,
        output bcd0
    );
endinterface

// File: rtl/sign_mag_bin2bcd_8b.sv
// Sign-magnitude to sign + 3-digit BCD converter using double dabble, one magnitude bit per clock.
// Result registers update only on the final shift, so the display never sees partial digits.
module sign_mag_bin2bcd_8b #(
    parameter int unsigned MAG_W             = 7,
    parameter int unsigned SUPPRESS_NEG_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sign_mag_bin2bcd_8b_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   mag_q,   mag_d;
    logic [11:0]        acc_q,   acc_d;
    logic [11:0]        acc_adj;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               neg_q,   neg_d;
    logic               zero_q,  zero_d;
    logic               sign_q,  sign_d;
    logic [11:0]        bcd_q,   bcd_d;

    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d   = bus.sm_in[MAG_W-1:0];
                    neg_d   = bus.sm_in[MAG_W];
                    zero_d  = (bus.sm_in[MAG_W-1:0] == '0);
                    acc_d   = '0;
                    cnt_d   = CNT_W'(MAG_W);
                    state_d = OP;
                end
            end
            OP: begin
                // Truncation drops a bit that is always zero: values stay below 1000.
                acc_d = 12'({acc_adj, mag_q[MAG_W-1]});
                mag_d = mag_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    bcd_d   = acc_d;
                    sign_d  = ((SUPPRESS_NEG_ZERO != 0) && zero_q) ? 1'b0 : neg_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.sign      = sign_q;
    assign bus.bcd2      = bcd_q[11:8];
    assign bus.bcd1      = bcd_q[7:4];
    assign bus.bcd0      = bcd_q[3:0];
endmodule

// File: tb/tb_sign_mag_bin2bcd_8b.sv
// Bench for sign_mag_bin2bcd_8b: table vectors plus corner sequences, results checked
// by a scoreboard monitor on the falling edge against bench-computed decimal digits.
module tb_sign_mag_bin2bcd_8b;
    localparam int unsigned MAG_W = 7;
    localparam int          LAT   = 7;
    localparam int          SPACE = 9;

    typedef struct {
        logic [7:0] v;
        logic       s;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } vec_t;

    typedef struct {
        logic       s;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        int         start_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   done_cnt;
    exp_t sb[$];

    logic       hold_s;
    logic [3:0] hold_d2, hold_d1, hold_d0;
    logic       chk_ready_next;

    sign_mag_bin2bcd_8b_if #(.MAG_W(MAG_W)) bus   ();
    sign_mag_bin2bcd_8b_if #(.MAG_W(MAG_W)) bus_b ();

    sign_mag_bin2bcd_8b #(.MAG_W(MAG_W), .SUPPRESS_NEG_ZERO(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sign_mag_bin2bcd_8b #(.MAG_W(MAG_W), .SUPPRESS_NEG_ZERO(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        done_cnt = 0;
        total = 0;
        bad = 0;
        hold_s = 1'b0;
        hold_d2 = '0;
        hold_d1 = '0;
        hold_d0 = '0;
        chk_ready_next = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic model(input logic [7:0] v, output logic s,
                         output logic [3:0] d2, output logic [3:0] d1, output logic [3:0] d0);
        int m;
        m  = int'(v[6:0]);
        s  = v[7] && (m != 0);
        d2 = 4'(m / 100);
        d1 = 4'((m / 10) % 10);
        d0 = 4'(m % 10);
    endtask

    // Scoreboard monitor for dut_a
    always @(negedge clk) begin
        if (rst) begin
            hold_s <= 1'b0;
            hold_d2 <= '0;
            hold_d1 <= '0;
            hold_d0 <= '0;
            chk_ready_next <= 1'b0;
        end else begin
            chk("done_ready_excl", int'(bus.done_tick & bus.ready), 0);
            if (chk_ready_next) chk("ready_after_done", int'(bus.ready), 1);
            chk_ready_next <= bus.done_tick;
            if (bus.done_tick) begin
                done_cnt <= done_cnt + 1;
                chk("sb_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("sign", int'(bus.sign), int'(sb[0].s));
                    chk("bcd2", int'(bus.bcd2), int'(sb[0].d2));
                    chk("bcd1", int'(bus.bcd1), int'(sb[0].d1));
                    chk("bcd0", int'(bus.bcd0), int'(sb[0].d0));
                    chk("latency", cyc - sb[0].start_cyc, LAT);
                    sb.delete(0);
                end
                hold_s <= bus.sign;
                hold_d2 <= bus.bcd2;
                hold_d1 <= bus.bcd1;
                hold_d0 <= bus.bcd0;
            end else begin
                chk("hold_sign", int'(bus.sign), int'(hold_s));
                chk("hold_bcd2", int'(bus.bcd2), int'(hold_d2));
                chk("hold_bcd1", int'(bus.bcd1), int'(hold_d1));
                chk("hold_bcd0", int'(bus.bcd0), int'(hold_d0));
            end
        end
    end

    // All drive tasks are entered and left just after a rising edge.
    task automatic issue(input logic [7:0] v, input logic s,
                         input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", int'(bus.ready), 1);
        bus.sm_in = v;
        bus.start = 1'b1;
        e.s = s;
        e.d2 = d2;
        e.d1 = d1;
        e.d0 = d0;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic conv(input logic [7:0] v, input logic s,
                        input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        issue(v, s, d2, d1, d0);
        wait_drain();
    endtask

    task automatic conv_b(input logic [7:0] v, input logic s,
                          input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        int n;
        n = 0;
        chk("b_ready", int'(bus_b.ready), 1);
        bus_b.sm_in = v;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        @(negedge clk);
        while (!bus_b.done_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_seen", int'(bus_b.done_tick), 1);
        chk("b_sign", int'(bus_b.sign), int'(s));
        chk("b_bcd2", int'(bus_b.bcd2), int'(d2));
        chk("b_bcd1", int'(bus_b.bcd1), int'(d1));
        chk("b_bcd0", int'(bus_b.bcd0), int'(d0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl[10];
        logic [7:0] rv;
        logic       rs;
        logic [3:0] r2, r1, r0;
        int         dc0;
        int         last_acc;
        int         n;

        tbl[0] = '{8'h7F, 1'b0, 4'd1, 4'd2, 4'd7};
        tbl[1] = '{8'hFF, 1'b1, 4'd1, 4'd2, 4'd7};
        tbl[2] = '{8'h85, 1'b1, 4'd0, 4'd0, 4'd5};
        tbl[3] = '{8'h0A, 1'b0, 4'd0, 4'd1, 4'd0};
        tbl[4] = '{8'h80, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[5] = '{8'h63, 1'b0, 4'd0, 4'd9, 4'd9};
        tbl[6] = '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[7] = '{8'hC8, 1'b1, 4'd0, 4'd7, 4'd2};
        tbl[8] = '{8'h40, 1'b0, 4'd0, 4'd6, 4'd4};
        tbl[9] = '{8'h81, 1'b1, 4'd0, 4'd0, 4'd1};

        bus.start = 1'b0;
        bus.sm_in = '0;
        bus_b.start = 1'b0;
        bus_b.sm_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_done", int'(bus.done_tick), 0);
        chk("rst_sign", int'(bus.sign), 0);
        chk("rst_digits", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            conv(tbl[i].v, tbl[i].s, tbl[i].d2, tbl[i].d1, tbl[i].d0);
        end

        for (int i = 0; i < 6; i++) begin
            rv = 8'($urandom_range(0, 255));
            model(rv, rs, r2, r1, r0);
            conv(rv, rs, r2, r1, r0);
        end

        // Negative zero keeps its sign when suppression is off
        conv_b(8'h80, 1'b1, 4'd0, 4'd0, 4'd0);
        conv_b(8'h85, 1'b1, 4'd0, 4'd0, 4'd5);

        // start and sm_in activity during OP must not disturb the running conversion
        dc0 = done_cnt;
        issue(8'h7F, 1'b0, 4'd1, 4'd2, 4'd7);
        @(posedge clk); #1;
        bus.sm_in = 8'h01;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.sm_in = 8'hFF;
        @(posedge clk); #1;
        bus.sm_in = 8'h33;
        wait_drain();
        repeat (12) @(posedge clk);
        #1;
        chk("ignored_start_done_count", done_cnt - dc0, 1);

        // Reset on the third OP cycle discards the conversion
        conv(8'h63, 1'b0, 4'd0, 4'd9, 4'd9);
        dc0 = done_cnt;
        bus.sm_in = 8'h7F;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", int'(bus.ready), 0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_done", int'(bus.done_tick), 0);
        chk("midrst_sign", int'(bus.sign), 0);
        chk("midrst_bcd2", int'(bus.bcd2), 0);
        chk("midrst_bcd1", int'(bus.bcd1), 0);
        chk("midrst_bcd0", int'(bus.bcd0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - dc0, 0);
        conv(8'h01, 1'b0, 4'd0, 4'd0, 4'd1);

        // start held high: back-to-back conversions
        bus.sm_in = 8'hC8;
        bus.start = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            n = 0;
            @(negedge clk);
            while (!bus.ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("stream_ready", int'(bus.ready), 1);
            e.s = 1'b1;
            e.d2 = 4'd0;
            e.d1 = 4'd7;
            e.d0 = 4'd2;
            e.start_cyc = cyc + 1;
            sb.push_back(e);
            if (i > 0) chk("stream_spacing", cyc + 1 - last_acc, SPACE);
            last_acc = cyc + 1;
            @(posedge clk);
        end
        #1;
        bus.start = 1'b0;
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
